// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter: serialises resolved-branch updates from two execute pipes
// onto the predictor's single update port through a small in-order queue.
// After every reset an init sweep writes not-taken history to every BHT line
// before any real update is accepted.

module bp_update_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned INIT_COUNT = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ex0_valid,
  output logic        ex0_ready,
  input  logic [31:0] ex0_pc,
  input  logic        ex0_taken,
  input  logic [31:0] ex0_target,

  input  logic        ex1_valid,
  output logic        ex1_ready,
  input  logic [31:0] ex1_pc,
  input  logic        ex1_taken,
  input  logic [31:0] ex1_target,

  output logic        update,
  output logic [31:0] update_pc,
  output logic        act_taken,
  output logic [31:0] act_target,
  output logic        init_done
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned IDX_W   = (INIT_COUNT > 1) ? $clog2(INIT_COUNT) : 1;
  localparam int unsigned ENTRY_W = 65;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Control state
  state_e             state_q,   state_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [CNT_W-1:0]   count_q,   count_d;

  // Queue storage: {pc, taken, target}
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  // Registered outputs
  logic               update_q,     update_d;
  logic [31:0]        update_pc_q,  update_pc_d;
  logic               act_taken_q,  act_taken_d;
  logic [31:0]        act_target_q, act_target_d;
  logic               init_done_q,  init_done_d;
  logic               ex0_ready_q,  ex0_ready_d;
  logic               ex1_ready_q,  ex1_ready_d;

  // Transfer qualifiers; readiness is the registered view of the queue count
  logic               push0;
  logic               push1;
  logic               pop;
  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;

  assign push0  = ex0_valid & ex0_ready_q;
  assign push1  = ex1_valid & ex1_ready_q;
  assign pop    = (state_q == ST_RUN) && (count_q != '0);
  assign entry0 = {ex0_pc, ex0_taken, ex0_target};
  assign entry1 = {ex1_pc, ex1_taken, ex1_target};

  // Next-state, queue bookkeeping and output register values
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    update_d     = 1'b0;
    update_pc_d  = update_pc_q;
    act_taken_d  = act_taken_q;
    act_target_d = act_target_q;
    init_done_d  = 1'b0;
    ex0_ready_d  = 1'b0;
    ex1_ready_d  = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Sweep: one not-taken write per BHT line, BTB untouched
        update_d     = 1'b1;
        update_pc_d  = {19'b0, 10'(idx_q), 3'b000};
        act_taken_d  = 1'b0;
        act_target_d = 32'b0;
        if (idx_q == IDX_W'(INIT_COUNT - 1)) begin
          state_d = ST_RUN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (pop) begin
          update_d = 1'b1;
          {update_pc_d, act_taken_d, act_target_d} = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
    endcase

    // Older pipe always lands first so issue order follows program order
    if (push0 && push1) begin
      mem_d[wr_ptr_q]              = entry0;
      mem_d[wr_ptr_q + PTR_W'(1)]  = entry1;
      wr_ptr_d                     = wr_ptr_q + PTR_W'(2);
    end else if (push0) begin
      mem_d[wr_ptr_q] = entry0;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (push1) begin
      mem_d[wr_ptr_q] = entry1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);

    // Ready for the next cycle reflects the count that cycle will see
    if (state_q == ST_RUN) begin
      ex0_ready_d = (count_d <= CNT_W'(DEPTH - 1));
      ex1_ready_d = (count_d <= CNT_W'(DEPTH - 2));
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      update_q     <= 1'b0;
      update_pc_q  <= 32'b0;
      act_taken_q  <= 1'b0;
      act_target_q <= 32'b0;
      init_done_q  <= 1'b0;
      ex0_ready_q  <= 1'b0;
      ex1_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      update_q     <= update_d;
      update_pc_q  <= update_pc_d;
      act_taken_q  <= act_taken_d;
      act_target_q <= act_target_d;
      init_done_q  <= init_done_d;
      ex0_ready_q  <= ex0_ready_d;
      ex1_ready_q  <= ex1_ready_d;
    end
  end

  // Queue storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ex0_ready  = ex0_ready_q;
  assign ex1_ready  = ex1_ready_q;
  assign update     = update_q;
  assign update_pc  = update_pc_q;
  assign act_taken  = act_taken_q;
  assign act_target = act_target_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: random and directed traffic compared each cycle
// against a queue-based reference model of the arbiter's behaviour.

module tb_bp_update_arbiter;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned INIT_COUNT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex0_valid, ex0_ready, ex0_taken;
  logic [31:0] ex0_pc, ex0_target;
  logic        ex1_valid, ex1_ready, ex1_taken;
  logic [31:0] ex1_pc, ex1_target;
  logic        update, act_taken, init_done;
  logic [31:0] update_pc, act_target;

  always #5 clk = ~clk;

  bp_update_arbiter #(.DEPTH(DEPTH), .INIT_COUNT(INIT_COUNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex0_valid  (ex0_valid),
    .ex0_ready  (ex0_ready),
    .ex0_pc     (ex0_pc),
    .ex0_taken  (ex0_taken),
    .ex0_target (ex0_target),
    .ex1_valid  (ex1_valid),
    .ex1_ready  (ex1_ready),
    .ex1_pc     (ex1_pc),
    .ex1_taken  (ex1_taken),
    .ex1_target (ex1_target),
    .update     (update),
    .update_pc  (update_pc),
    .act_taken  (act_taken),
    .act_target (act_target),
    .init_done  (init_done)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  bit          m_init = 1'b1;
  int unsigned m_idx  = 0;
  ent_t        m_q[$];
  logic        exp_update, exp_taken, exp_done, exp_rdy0, exp_rdy1;
  logic [31:0] exp_pc, exp_target;
  bit          acc0, acc1;
  int unsigned n_acc0 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs as driven before it
  task automatic model_edge();
    ent_t e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      m_init = 1'b1;
      m_idx  = 0;
      m_q.delete();
      exp_update = 1'b0; exp_pc = '0; exp_taken = 1'b0; exp_target = '0;
      exp_done = 1'b0; exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
    end else if (m_init) begin
      exp_update = 1'b1;
      exp_pc     = 32'(m_idx * 8);
      exp_taken  = 1'b0;
      exp_target = '0;
      exp_done   = 1'b0;
      exp_rdy0   = 1'b0;
      exp_rdy1   = 1'b0;
      m_idx++;
      if (m_idx == INIT_COUNT) m_init = 1'b0;
    end else begin
      acc0 = ex0_valid && exp_rdy0;
      acc1 = ex1_valid && exp_rdy1;
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        exp_update = 1'b1;
        exp_pc     = e.pc;
        exp_taken  = e.taken;
        exp_target = e.target;
      end else begin
        exp_update = 1'b0;
      end
      if (acc0) m_q.push_back('{ex0_pc, ex0_taken, ex0_target});
      if (acc1) m_q.push_back('{ex1_pc, ex1_taken, ex1_target});
      exp_done = 1'b1;
      exp_rdy0 = (m_q.size() <= int'(DEPTH) - 1);
      exp_rdy1 = (m_q.size() <= int'(DEPTH) - 2);
    end
  endtask

  // One clock: model, compare, then retire accepted requests and raise new ones
  task automatic step(input int unsigned pct0, input int unsigned pct1);
    @(posedge clk);
    model_edge();
    #1;
    check("update",     64'(update),     64'(exp_update));
    check("update_pc",  64'(update_pc),  64'(exp_pc));
    check("act_taken",  64'(act_taken),  64'(exp_taken));
    check("act_target", 64'(act_target), 64'(exp_target));
    check("init_done",  64'(init_done),  64'(exp_done));
    check("ex0_ready",  64'(ex0_ready),  64'(exp_rdy0));
    check("ex1_ready",  64'(ex1_ready),  64'(exp_rdy1));
    if (acc0) n_acc0++;
    if (rst || acc0) ex0_valid = 1'b0;
    if (rst || acc1) ex1_valid = 1'b0;
    if (!ex0_valid && $urandom_range(99) < pct0) begin
      ex0_valid  = 1'b1;
      ex0_pc     = $urandom & 32'hffff_fffc;
      ex0_taken  = 1'($urandom);
      ex0_target = $urandom & 32'hffff_fffc;
    end
    if (!ex1_valid && $urandom_range(99) < pct1) begin
      ex1_valid  = 1'b1;
      ex1_pc     = $urandom & 32'hffff_fffc;
      ex1_taken  = 1'($urandom);
      ex1_target = $urandom & 32'hffff_fffc;
    end
  endtask

  initial begin
    rst = 1'b1;
    ex0_valid = 1'b0; ex0_pc = '0; ex0_taken = 1'b0; ex0_target = '0;
    ex1_valid = 1'b0; ex1_pc = '0; ex1_taken = 1'b0; ex1_target = '0;

    // Reset values, then the sweep and idle RUN
    repeat (3) step(0, 0);
    rst = 1'b0;
    repeat (INIT_COUNT + 3) step(0, 0);

    // Single push from ex0
    ex0_valid = 1'b1; ex0_pc = 32'h1000; ex0_taken = 1'b1; ex0_target = 32'h2000;
    repeat (4) step(0, 0);

    // Dual push in one cycle
    ex0_valid = 1'b1; ex0_pc = 32'h100; ex0_taken = 1'b0; ex0_target = 32'h180;
    ex1_valid = 1'b1; ex1_pc = 32'h104; ex1_taken = 1'b1; ex1_target = 32'h200;
    repeat (5) step(0, 0);

    // Sustained dual-pipe traffic, then drain
    repeat (20) step(100, 100);
    repeat (DEPTH + 2) step(0, 0);

    // Twenty single pushes with random gaps to wrap the pointers
    n_acc0 = 0;
    for (int i = 0; i < 400 && n_acc0 < 20; i++) step(30, 0);
    check("wrap_accepts", 64'(n_acc0 >= 20), 64'(1));
    ex0_valid = 1'b0;
    repeat (DEPTH + 2) step(0, 0);

    // Mixed random traffic
    repeat (150) step(50, 50);
    ex0_valid = 1'b0;
    ex1_valid = 1'b0;
    repeat (DEPTH + 2) step(0, 0);

    // Queue three entries, then reset mid-run
    ex0_valid = 1'b1; ex0_pc = 32'ha000; ex0_taken = 1'b1; ex0_target = 32'hb000;
    ex1_valid = 1'b1; ex1_pc = 32'ha004; ex1_taken = 1'b0; ex1_target = 32'hb004;
    step(0, 0);
    ex0_valid = 1'b1; ex0_pc = 32'ha008; ex0_taken = 1'b1; ex0_target = 32'hb008;
    ex1_valid = 1'b1; ex1_pc = 32'ha00c; ex1_taken = 1'b1; ex1_target = 32'hb00c;
    step(0, 0);
    check("queued_before_rst", 64'(m_q.size()), 64'(3));
    ex0_valid = 1'b0;
    ex1_valid = 1'b0;
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    repeat (INIT_COUNT + 4) step(0, 0);
    repeat (40) step(60, 60);
    ex0_valid = 1'b0;
    ex1_valid = 1'b0;
    repeat (DEPTH + 2) step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
